// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one single-port unified memory between the fetch
// (IF) and data (MEM) ports. Each access is held for WAIT_STATES+1 cycles and
// is followed by a one-cycle completion pulse. Data normally has priority.
// Optional build macro MEM_ARB_FAIR_EN adds a starve counter that forces a
// fetch grant after MAX_STARVE consecutive data grants made while fetch waited.
module mem_port_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MAX_STARVE  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic [31:0] if_rdata,
  output logic        if_valid,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic [31:0] dm_rdata,
  output logic        dm_valid,
  output logic        mem_en,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  output logic        stall_f,
  output logic        stall_m
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    ACC_I  = 3'd1,
    ACC_D  = 3'd2,
    RESP_I = 3'd3,
    RESP_D = 3'd4
  } state_t;

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             we_q;
  logic             mem_en_q;
  logic             mem_we_q;
  logic [31:0]      mem_addr_q;
  logic [31:0]      mem_wdata_q;
  logic [31:0]      if_rdata_q;
  logic [31:0]      dm_rdata_q;
  logic             if_valid_q;
  logic             dm_valid_q;

  logic             gnt_i_d;
  logic             gnt_d_d;
  logic             last_d;
  logic             we_next_d;
  logic             starved_d;

`ifdef MEM_ARB_FAIR_EN
  localparam int unsigned SCNT_W = (MAX_STARVE > 0) ? $clog2(MAX_STARVE + 1) : 1;

  logic [SCNT_W-1:0] scnt_q;

  assign starved_d = (scnt_q == SCNT_W'(MAX_STARVE));

  // Starve counter: counts data grants taken while fetch was waiting.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scnt_q <= '0;
    end else if (state_q == IDLE) begin
      if (gnt_i_d) begin
        scnt_q <= '0;
      end else if (gnt_d_d && if_req) begin
        scnt_q <= scnt_q + SCNT_W'(1);
      end
    end
  end
`else
  assign starved_d = 1'b0;
`endif

  // Grant decision in IDLE: data wins unless fetch has been starved.
  assign gnt_i_d   = if_req & (~dm_req | starved_d);
  assign gnt_d_d   = dm_req & ~gnt_i_d;
  assign last_d    = (cnt_q == CNT_W'(WAIT_STATES));
  assign we_next_d = (CNT_W'(cnt_q + CNT_W'(1)) == CNT_W'(WAIT_STATES));

  // Arbiter FSM with all memory-side and response outputs registered.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_rdata_q  <= '0;
      dm_rdata_q  <= '0;
      if_valid_q  <= 1'b0;
      dm_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (gnt_d_d) begin
            state_q     <= ACC_D;
            we_q        <= dm_we;
            mem_en_q    <= 1'b1;
            mem_we_q    <= dm_we & (CNT_W'(WAIT_STATES) == '0);
            mem_addr_q  <= dm_addr;
            mem_wdata_q <= dm_wdata;
          end else if (gnt_i_d) begin
            state_q    <= ACC_I;
            we_q       <= 1'b0;
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr;
          end
        end
        ACC_I, ACC_D: begin
          if (last_d) begin
            mem_en_q <= 1'b0;
            mem_we_q <= 1'b0;
            cnt_q    <= '0;
            if (state_q == ACC_I) begin
              if_rdata_q <= mem_rdata;
              if_valid_q <= 1'b1;
              state_q    <= RESP_I;
            end else begin
              if (!we_q) begin
                dm_rdata_q <= mem_rdata;
              end
              dm_valid_q <= 1'b1;
              state_q    <= RESP_D;
            end
          end else begin
            cnt_q    <= cnt_q + CNT_W'(1);
            mem_we_q <= (state_q == ACC_D) & we_q & we_next_d;
          end
        end
        RESP_I, RESP_D: begin
          if_valid_q <= 1'b0;
          dm_valid_q <= 1'b0;
          state_q    <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign if_rdata  = if_rdata_q;
  assign if_valid  = if_valid_q;
  assign dm_rdata  = dm_rdata_q;
  assign dm_valid  = dm_valid_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;

  // Stalls go straight to hazard logic, unregistered.
  assign stall_f = if_req & ~if_valid_q;
  assign stall_m = dm_req & ~dm_valid_q;

endmodule
